// File: rtl/avalon_st_rr_arbiter.sv
// Packet-level round-robin merge of two Avalon-ST sources into one registered output stream.
// The grant is locked from sop to eop so packets never interleave on the output.
//
// state   | meaning
// ST_IDLE | between packets; next sop beat picks the source round-robin
// ST_PKT  | packet in flight; only owner_q may transfer until its eop beat
module avalon_st_rr_arbiter #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [DATA_WIDTH-1:0]  in0_data,
  input  logic                   in0_valid,
  input  logic                   in0_sop,
  input  logic                   in0_eop,
  input  logic [EMPTY_WIDTH-1:0] in0_empty,
  output logic                   in0_ready,

  input  logic [DATA_WIDTH-1:0]  in1_data,
  input  logic                   in1_valid,
  input  logic                   in1_sop,
  input  logic                   in1_eop,
  input  logic [EMPTY_WIDTH-1:0] in1_empty,
  output logic                   in1_ready,

  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   out_channel,
  input  logic                   out_ready,

  output logic [CNT_WIDTH-1:0]   pkt_cnt0,
  output logic [CNT_WIDTH-1:0]   pkt_cnt1,
  output logic [15:0]            err_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t                 state_q;
  logic                   owner_q;
  logic                   last_q;

  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_valid_q;
  logic                   out_sop_q;
  logic                   out_eop_q;
  logic [EMPTY_WIDTH-1:0] out_empty_q;
  logic                   out_channel_q;

  logic [CNT_WIDTH-1:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt1_q, pkt_cnt1_d;
  logic [15:0]            err_cnt_q,  err_cnt_d;

  logic                   sel;
  logic                   load;
  logic                   grant_ok;
  logic                   accept;
  logic                   fwd;
  logic                   drop;
  logic                   pkt_done;

  logic [DATA_WIDTH-1:0]  s_data;
  logic                   s_valid;
  logic                   s_sop;
  logic                   s_eop;
  logic [EMPTY_WIDTH-1:0] s_empty;

  // When idle with both sources valid the source not granted last wins; with
  // neither valid we park on last_q so its ready is the one offered.
  always_comb begin
    sel = last_q;
    if (state_q == ST_PKT) begin
      sel = owner_q;
    end else if (in0_valid && !in1_valid) begin
      sel = 1'b0;
    end else if (!in0_valid && in1_valid) begin
      sel = 1'b1;
    end else if (in0_valid && in1_valid) begin
      sel = ~last_q;
    end
  end

  always_comb begin
    s_data  = in0_data;
    s_valid = in0_valid;
    s_sop   = in0_sop;
    s_eop   = in0_eop;
    s_empty = in0_empty;
    if (sel) begin
      s_data  = in1_data;
      s_valid = in1_valid;
      s_sop   = in1_sop;
      s_eop   = in1_eop;
      s_empty = in1_empty;
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign grant_ok = load && !rst;
  assign in0_ready = grant_ok && !sel;
  assign in1_ready = grant_ok && sel;

  assign accept   = grant_ok && s_valid;
  assign fwd      = accept && ((state_q == ST_PKT) || s_sop);
  assign drop     = accept && (state_q == ST_IDLE) && !s_sop;
  assign pkt_done = fwd && s_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= fwd;
        if (fwd) begin
          out_data_q    <= s_data;
          out_sop_q     <= s_sop;
          out_eop_q     <= s_eop;
          out_empty_q   <= s_empty;
          out_channel_q <= sel;
        end
      end
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (s_sop) begin
              if (s_eop) begin
                last_q <= sel;
              end else begin
                state_q <= ST_PKT;
                owner_q <= sel;
              end
            end
          end
          ST_PKT: begin
            // a stray sop mid-packet is forwarded like any other body beat
            if (s_eop) begin
              state_q <= ST_IDLE;
              last_q  <= sel;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    err_cnt_d  = err_cnt_q;
    if (pkt_done && !sel) begin
      pkt_cnt0_d = pkt_cnt0_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    if (pkt_done && sel) begin
      pkt_cnt1_d = pkt_cnt1_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    if (drop && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_empty   = out_empty_q;
  assign out_channel = out_channel_q;
  assign pkt_cnt0    = pkt_cnt0_q;
  assign pkt_cnt1    = pkt_cnt1_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Bench for avalon_st_rr_arbiter: queued sources, an acceptance-time scoreboard,
// and directed scenarios for alternation, lock, backpressure, errors and reset.
module tb_avalon_st_rr_arbiter;
  localparam int DW = 512;
  localparam int EW = 6;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          in0_valid = 1'b0, in0_sop = 1'b0, in0_eop = 1'b0, in0_ready;
  logic          in1_valid = 1'b0, in1_sop = 1'b0, in1_eop = 1'b0, in1_ready;
  logic [EW-1:0] in0_empty = '0, in1_empty = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop, out_channel;
  logic          out_ready = 1'b1;
  logic [EW-1:0] out_empty;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
  logic [15:0]   err_cnt;

  avalon_st_rr_arbiter #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop), .in0_eop(in0_eop),
    .in0_empty(in0_empty), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop), .in1_eop(in1_eop),
    .in1_empty(in1_empty), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_channel(out_channel), .out_ready(out_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          ch;
  } beat_t;

  typedef struct {
    int   cyc;
    logic ch;
  } log_t;

  beat_t q0[$], q1[$], sb[$];
  log_t  ch_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt0 = 0, acc_cnt1 = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;

  logic          busy_m = 1'b0, owner_m = 1'b0;
  logic [CW-1:0] pkt_exp0 = '0, pkt_exp1 = '0;
  logic [15:0]   err_exp = '0;

  logic          stall_q = 1'b0;
  logic [DW-1:0] held_data;
  logic [10:0]   held_ctrl;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_accept(input beat_t b);
    if (busy_m) check_eq("lock_owner", DW'(b.ch), DW'(owner_m));
    if (!busy_m && !b.sop) begin
      if (err_exp != 16'hFFFF) err_exp++;
    end else begin
      sb.push_back(b);
      if (!busy_m && !b.eop) begin
        busy_m  = 1'b1;
        owner_m = b.ch;
      end else if (b.eop) begin
        busy_m = 1'b0;
        if (b.ch) pkt_exp1++;
        else      pkt_exp0++;
      end
    end
  endtask

  task automatic push_pkt(input int k, input int n, input logic [EW-1:0] emp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < DW/32; j++) b.data[j*32 +: 32] = $urandom;
      b.sop   = (i == 0);
      b.eop   = (i == n-1);
      b.empty = (i == n-1) ? emp : '0;
      b.ch    = (k != 0);
      if (k == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output checking first, then input acceptance for this edge
  always @(negedge clk) begin
    beat_t e, b;
    if (stall_q) begin
      check_eq("hold_data", out_data, held_data);
      check_eq("hold_ctrl", DW'({out_valid, out_channel, out_sop, out_eop, out_empty}), DW'(held_ctrl));
    end
    if (out_valid && !out_ready) check_eq("stall_ready", DW'({in0_ready, in1_ready}), DW'(2'b00));
    stall_q   = out_valid && !out_ready;
    held_data = out_data;
    held_ctrl = {out_valid, out_channel, out_sop, out_eop, out_empty};
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("out_unexpected", DW'(out_valid), DW'(1'b0));
      end else begin
        e = sb.pop_front();
        check_eq("out_data", out_data, e.data);
        check_eq("out_ctrl", DW'({out_channel, out_sop, out_eop, out_empty}),
                 DW'({e.ch, e.sop, e.eop, e.empty}));
      end
      ch_log.push_back('{cyc, out_channel});
    end
    check_eq("pkt_cnt0", DW'(pkt_cnt0), DW'(pkt_exp0));
    check_eq("pkt_cnt1", DW'(pkt_cnt1), DW'(pkt_exp1));
    check_eq("err_cnt", DW'(err_cnt), DW'(err_exp));
    if (rst) begin
      busy_m = 1'b0; pkt_exp0 = '0; pkt_exp1 = '0; err_exp = '0;
      acc0 = 1'b0; acc1 = 1'b0; stall_q = 1'b0;
    end else begin
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      check_eq("single_grant", DW'(acc0 && acc1), DW'(1'b0));
      if (acc0) begin
        b = '{in0_data, in0_sop, in0_eop, in0_empty, 1'b0};
        acc_cnt0++;
        model_accept(b);
      end
      if (acc1) begin
        b = '{in1_data, in1_sop, in1_eop, in1_empty, 1'b1};
        acc_cnt1++;
        model_accept(b);
      end
    end
  end

  // Source driver: holds the head beat until it is accepted
  initial begin
    forever begin
      @(posedge clk); #2;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      in0_valid = (q0.size() > 0);
      if (in0_valid) begin
        in0_data = q0[0].data; in0_sop = q0[0].sop; in0_eop = q0[0].eop; in0_empty = q0[0].empty;
      end
      in1_valid = (q1.size() > 0);
      if (in1_valid) begin
        in1_data = q1[0].data; in1_sop = q1[0].sop; in1_eop = q1[0].eop; in1_empty = q1[0].empty;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(posedge clk); #3;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #3;
      n++;
    end
    if (n >= budget) check_eq("idle_timeout", DW'(q0.size() + q1.size() + sb.size()), DW'(0));
  endtask

  task automatic check_log(input string tag, input int n, input logic [63:0] chans);
    check_eq({tag, "_len"}, DW'(ch_log.size()), DW'(n));
    for (int i = 0; i < ch_log.size() && i < n; i++) begin
      check_eq({tag, "_ch"}, DW'(ch_log[i].ch), DW'(chans[i]));
      if (i > 0) check_eq({tag, "_gap"}, DW'(ch_log[i].cyc - ch_log[i-1].cyc), DW'(1));
    end
  endtask

  int          base0;
  int          pushed;
  int          seen;
  int          pat[16] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  logic [63:0] exp_ch;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", DW'({in0_ready, in1_ready}), DW'(2'b00));
    check_eq("rst_oval", DW'(out_valid), DW'(1'b0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready_last1", DW'({in0_ready, in1_ready}), DW'(2'b01));
    check_eq("idle_oval", DW'(out_valid), DW'(1'b0));

    // alternation of 3-beat packets, source 0 first after reset
    @(posedge clk); #1;
    ch_log.delete();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 3, 6'd1);
      push_pkt(1, 3, 6'd2);
    end
    wait_idle(200);
    exp_ch = '0;
    for (int i = 0; i < 24; i++) exp_ch[i] = ((i / 3) % 2) != 0;
    check_log("alt", 24, exp_ch);
    check_eq("alt_cnt0", DW'(pkt_cnt0), DW'(4));
    check_eq("alt_cnt1", DW'(pkt_cnt1), DW'(4));

    // lock: source 1 arrives mid-way through a 5-beat source 0 packet
    @(posedge clk); #1;
    ch_log.delete();
    base0 = acc_cnt0;
    push_pkt(0, 5, 6'd3);
    pushed = 0;
    seen   = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(posedge clk); #3;
      if (pushed == 0 && acc_cnt0 - base0 >= 2) begin
        push_pkt(1, 3, 6'd4);
        pushed = 1;
      end else if (pushed != 0 && acc_cnt0 - base0 < 5) begin
        check_eq("lock_rdy1", DW'(in1_ready), DW'(1'b0));
      end else if (pushed != 0) begin
        check_eq("lock_release", DW'(in1_ready), DW'(1'b1));
        seen = 1;
      end
    end
    if (seen == 0) check_eq("lock_timeout", DW'(seen), DW'(1));
    wait_idle(100);
    check_log("lock", 8, 64'hE0);
    check_eq("lock_cnt0", DW'(pkt_cnt0), DW'(5));
    check_eq("lock_cnt1", DW'(pkt_cnt1), DW'(5));

    // backpressure during a 6-beat packet
    @(posedge clk); #1;
    ch_log.delete();
    push_pkt(0, 6, 6'd9);
    for (int i = 0; i < 16; i++) begin
      out_ready = (pat[i] != 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle(100);
    check_eq("bp_len", DW'(ch_log.size()), DW'(6));
    check_eq("bp_cnt0", DW'(pkt_cnt0), DW'(6));

    // single-beat packets from source 1 only
    @(posedge clk); #1;
    ch_log.delete();
    for (int i = 0; i < 6; i++) push_pkt(1, 1, 6'd17);
    wait_idle(100);
    check_log("single", 6, 64'h3F);
    check_eq("single_cnt1", DW'(pkt_cnt1), DW'(11));

    // protocol error: sop=0 while idle is dropped and counted
    @(posedge clk); #1;
    ch_log.delete();
    q0.push_back('{'0, 1'b0, 1'b0, '0, 1'b0});
    wait_idle(20);
    check_eq("err_one", DW'(err_cnt), DW'(1));
    check_eq("err_not_fwd", DW'(ch_log.size()), DW'(0));
    for (int i = 0; i < 65540; i++) q0.push_back('{DW'(i), 1'b0, 1'b0, '0, 1'b0});
    wait_idle(70000);
    check_eq("err_sat", DW'(err_cnt), DW'(16'hFFFF));
    check_eq("err_sat_cnt0", DW'(pkt_cnt0), DW'(6));

    // reset in the middle of a 4-beat packet
    @(posedge clk); #1;
    base0 = acc_cnt0;
    push_pkt(0, 4, 6'd0);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (acc_cnt0 - base0 >= 2) seen = 1;
    end
    if (seen == 0) check_eq("rst_wait_timeout", DW'(acc_cnt0 - base0), DW'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    ch_log.delete();
    push_pkt(0, 2, 6'd5);
    push_pkt(1, 2, 6'd6);
    @(negedge clk);
    check_eq("mid_rst_oval", DW'(out_valid), DW'(1'b0));
    check_eq("mid_rst_cnt", DW'({pkt_cnt0, pkt_cnt1, err_cnt}), DW'(0));
    wait_idle(50);
    check_log("post_rst", 4, 64'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got cycle %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/avalon_st_rr_arbiter.md
Name: avalon_st_rr_arbiter

Overview:
- Packet-level round-robin arbiter. Merges two Avalon-ST sources (512-bit, sop/eop/empty) into one Avalon-ST stream.
- Typical use: feeding a shared packet FIFO or Ethernet TX path from two producers.
- Grant is locked from the sop beat to the eop beat, so packets never interleave.
- Single registered output stage; per-source packet counters and a protocol-error counter.

Parameters:
- DATA_WIDTH, 512, data bus width.
- EMPTY_WIDTH, 6, width of empty field (log2 of DATA_WIDTH/8).
- CNT_WIDTH, 32, width of packet counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in0_data  in  DATA_WIDTH  source 0 data.
- in0_valid / in0_sop / in0_eop  in  1 each  source 0 control.
- in0_empty  in  EMPTY_WIDTH  source 0 empty bytes on eop beat.
- in0_ready  out  1  source 0 ready.
- in1_data, in1_valid, in1_sop, in1_eop, in1_empty, in1_ready: same as source 0.
- out_data  out  DATA_WIDTH  merged data.
- out_valid / out_sop / out_eop  out  1 each  merged control.
- out_empty  out  EMPTY_WIDTH  merged empty.
- out_channel  out  1  source index of the current out beat.
- out_ready  in  1  downstream ready.
- pkt_cnt0, pkt_cnt1  out  CNT_WIDTH  packets forwarded per source.
- err_cnt  out  16  dropped protocol-violating beats.

Behaviour:
- Interface: Avalon-ST, readyLatency 0. A beat transfers when valid && ready in the same cycle.
- Reset (rst=1 at a clk edge): out_valid=0, busy=0, owner=0, last=1 (source 0 has priority after reset), pkt_cnt0=pkt_cnt1=0, err_cnt=0. in0_ready=in1_ready=0 while rst is asserted. Other out_* register values are don't-care while out_valid=0.
- Reset mid-packet: the packet is abandoned, nothing is flushed downstream, and no counter increments.
- State: busy (packet in progress) and owner (locked source); last (most recently granted source).
- Selection sel:
  - busy=1: sel=owner.
  - busy=0, only one source valid: sel = that source.
  - busy=0, both valid: sel = !last.
  - busy=0, neither valid: sel=last.
- Load enable: load = !out_valid || out_ready.
- Ready: in<k>_ready = load && (sel==k) && !rst. The unselected source's ready is 0.
- Accepted beat on sel:
  - busy=0, sop=1, eop=0: busy<=1, owner<=sel. Beat forwarded.
  - busy=0, sop=1, eop=1 (single-beat packet): forwarded; busy stays 0; last<=sel; pkt_cnt<sel>++.
  - busy=0, sop=0: beat dropped (not forwarded); err_cnt++ (saturates at 16'hFFFF).
  - busy=1, eop=1: forwarded; busy<=0; last<=sel; pkt_cnt<sel>++.
  - busy=1, any other beat: forwarded unchanged. A sop=1 beat mid-packet is forwarded as-is with no error count.
- Forwarding: on the load cycle the out registers take the accepted beat's data/sop/eop/empty, out_channel<=sel, out_valid<=1.
- If load=1 and no forwardable beat is accepted, out_valid<=0.
- Latency: accepted beat appears on out_* exactly 1 cycle later.
- Throughput: full rate when out_ready=1. No bubble between back-to-back packets, including a switch of source.
- Backpressure: out_ready=0 with out_valid=1 holds all out_* stable and forces both in_ready to 0.
- Counters: pkt_cnt wraps modulo 2^CNT_WIDTH; increment on the acceptance cycle, visible next cycle.
- Simultaneous sop on both sources while idle: exactly one is granted per the rule above. The loser's valid/data must be held by its source and is granted right after the winner's eop beat.

Test Plan:
- Alternation: both sources continuously offer 3-beat packets, out_ready=1 -> out_channel sequence 0,0,0,1,1,1,0,0,0...; no idle cycle between packets; pkt_cnt0=pkt_cnt1=N after N packets each.
- Lock: source 1 raises valid mid-way through source 0's 5-beat packet -> in1_ready stays 0 until the cycle after source 0's eop is accepted; the source 1 sop beat then appears on out_* the next cycle.
- Backpressure: out_ready toggles 1,0,0,1 during a packet -> out_* held stable while out_ready=0, no beat lost or duplicated, data order intact, in0_ready=0 on stall cycles.
- Single-beat packets: source 1 only, sop=eop=1, empty=6'd17 each beat -> out_sop=out_eop=1, out_empty=17, pkt_cnt1 increments every cycle, busy never set.
- Protocol error: idle, source 0 sends a valid beat with sop=0 -> beat not forwarded, out_valid=0 the next cycle, err_cnt=1. After 65536 such beats, err_cnt stays 16'hFFFF.
- Reset mid-packet: rst pulsed 1 cycle after beat 2 of 4 -> next cycle out_valid=0, counters 0. A fresh source 0 sop is then granted first even if source 1 is also valid.
